inv_pipe: RTL and testbench
===========================

INV_PIPE -- requirements
Module: inv_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width in bits (legal 1..64).
REQ-002 The block SHALL have parameter MASK_RST, default all ones, meaning the reset value of the invert mask.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port cfg_we  input  1  config write strobe.
REQ-006 The block SHALL have port cfg_mode  input  2  mode written on cfg_we.
REQ-007 The block SHALL have port cfg_mask  input  WIDTH  mask written on cfg_we.
REQ-008 The block SHALL have port in_valid  input  1  upstream beat valid.
REQ-009 The block SHALL have port in_ready  output  1  block can accept a beat.
REQ-010 The block SHALL have port in_data  input  WIDTH  upstream data.
REQ-011 The block SHALL have port out_valid  output  1  downstream beat valid.
REQ-012 The block SHALL have port out_ready  input  1  downstream accepts.
REQ-013 The block SHALL have port out_data  output  WIDTH  transformed data.
REQ-014 The block SHALL have port beat_cnt  output  16  count of beats delivered downstream.

Function
REQ-015 Modes: 0 BYPASS o=d; 1 INV_ALL o=~d; 2 INV_MASK o=d^mask; 3 INV_ALT, ~d on even-numbered accepted beats (0,2,4,...) and d on odd ones.
REQ-016 An input beat SHALL be accepted on a rising edge with in_valid && in_ready; an output beat SHALL complete on out_valid && out_ready.
REQ-017 The transform SHALL be computed from the mode/mask registers current at acceptance; queued beats keep their transform when config changes.
REQ-018 A cfg_we SHALL update the mode/mask registers at that edge; the new config SHALL apply to beats accepted on later edges, not one accepted on the same edge.
REQ-019 Storage SHALL be a 2-entry FIFO skid buffer; in_ready = (entries < 2), driven from a register with no combinational path from out_ready.
REQ-020 Latency SHALL be 1 cycle: a beat accepted at edge N is on out_data with out_valid high after edge N.
REQ-021 Throughput SHALL be 1 beat/cycle while out_ready stays high.
REQ-022 When full, in_ready SHALL be 0 and in_data SHALL be ignored; when empty, out_valid SHALL be 0.
REQ-023 Simultaneous accept and deliver at any occupancy SHALL leave the occupancy unchanged and keep beat order.
REQ-024 out_data SHALL stay stable while out_valid && !out_ready.
REQ-025 The INV_ALT parity bit SHALL toggle on every accepted beat in any mode and reset to even.
REQ-026 beat_cnt SHALL increment on each output beat and wrap from 0xFFFF to 0x0000.

Reset
REQ-027 While rst_n=0: FIFO empty, out_valid=0, in_ready=0, out_data=0, beat_cnt=0, mode=BYPASS, mask=MASK_RST, parity=even.
REQ-028 in_ready SHALL rise on the first edge after rst_n deasserts.
REQ-029 Reset mid-transfer SHALL drop all queued beats without delivering them.

Structure
REQ-030 Package inv_pipe_pkg SHALL hold the mode enum (BYPASS, INV_ALL, INV_MASK, INV_ALT) and the beat_cnt width constant.
REQ-031 The 2-entry buffer SHALL be a sub-module inv_pipe_skid, parameterised by WIDTH; the transform logic SHALL stay in inv_pipe.

Verification
REQ-032 WIDTH=8, INV_ALL, stream 0x00,0xA5,0xFF with out_ready=1 -> 0xFF,0x5A,0x00, each 1 cycle after accept; beat_cnt=3.
REQ-033 INV_MASK with mask 0x0F, in 0x3C -> 0x33; cfg_we with mask 0xF0 on the same edge as accepting 0x3C -> 0x33, next beat 0x3C -> 0xCC.
REQ-034 INV_ALT, four beats of 0x55 -> 0xAA,0x55,0xAA,0x55.
REQ-035 out_ready=0, push 3 beats -> 2 accepted, in_ready=0, out_data held; raise out_ready -> 2 beats delivered in order.
REQ-036 Preload beat_cnt to 0xFFFE by streaming, deliver 3 more -> 0xFFFF, 0x0000, 0x0001.
REQ-037 Assert rst_n=0 with 2 beats queued -> out_valid=0 immediately, beat_cnt=0; after release no stale beat appears.

Source files
------------

// File: rtl/inv_pipe_pkg.sv
// Shared types and constants for the inv_pipe data transform block.
package inv_pipe_pkg;

  typedef enum logic [1:0] {
    BYPASS   = 2'd0,
    INV_ALL  = 2'd1,
    INV_MASK = 2'd2,
    INV_ALT  = 2'd3
  } mode_e;

  localparam int BEAT_CNT_W = 16;

endpackage

// File: rtl/inv_pipe_skid.sv
// Two-entry skid FIFO: head register drives out_data, handshake outputs are registered.
module inv_pipe_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [1:0]       count_r;
  logic [1:0]       count_s;
  logic [WIDTH-1:0] tail_r;
  logic             push_s;
  logic             pop_s;

  // handshakes and next occupancy
  always_comb begin
    push_s  = in_valid & in_ready;
    pop_s   = out_valid & out_ready;
    count_s = count_r;
    if (push_s && !pop_s) begin
      count_s = count_r + 2'd1;
    end else if (!push_s && pop_s) begin
      count_s = count_r - 2'd1;
    end else begin
      count_s = count_r;
    end
  end

  // occupancy and flags derived from the next occupancy, so no path from out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r   <= 2'd0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      count_r   <= count_s;
      in_ready  <= (count_s != 2'd2);
      out_valid <= (count_s != 2'd0);
    end
  end

  // head/tail data movement; head is out_data and only changes on push-to-empty or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      tail_r   <= '0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            out_data <= in_data;
          end else begin
            tail_r <= in_data;
          end
        end
        2'b01: begin
          out_data <= tail_r;
        end
        2'b11: begin
          if (count_r == 2'd2) begin
            out_data <= tail_r;
            tail_r   <= in_data;
          end else begin
            out_data <= in_data;
          end
        end
        default: begin
          out_data <= out_data;
        end
      endcase
    end
  end

endmodule

// File: rtl/inv_pipe.sv
// Configurable invert pipeline: transforms each accepted beat and queues it in a 2-entry skid buffer.
module inv_pipe
  import inv_pipe_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MASK_RST = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_mode,
  input  logic [WIDTH-1:0]      cfg_mask,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [BEAT_CNT_W-1:0] beat_cnt
);

  mode_e            mode_r;
  logic [WIDTH-1:0] mask_r;
  logic             parity_r;
  logic             accept_s;
  logic [WIDTH-1:0] xf_data_s;

  function automatic logic [WIDTH-1:0] transform(input mode_e m, input logic [WIDTH-1:0] d,
                                                 input logic [WIDTH-1:0] mk, input logic odd);
    case (m)
      BYPASS:   return d;
      INV_ALL:  return ~d;
      INV_MASK: return d ^ mk;
      INV_ALT:  return odd ? d : ~d;
      default:  return d;
    endcase
  endfunction

  // transform uses the registers as they stand before this edge's cfg_we takes effect
  always_comb begin
    accept_s  = in_valid & in_ready;
    xf_data_s = transform(mode_r, in_data, mask_r, parity_r);
  end

  // configuration registers and beat parity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r   <= BYPASS;
      mask_r   <= MASK_RST;
      parity_r <= 1'b0;
    end else begin
      if (cfg_we) begin
        mode_r <= mode_e'(cfg_mode);
        mask_r <= cfg_mask;
      end
      if (accept_s) begin
        parity_r <= ~parity_r;
      end
    end
  end

  // delivered-beat counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
    end
  end

  inv_pipe_skid #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (xf_data_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_inv_pipe.sv
// Scoreboard bench for inv_pipe: driver issues beats/config, monitor predicts and checks each cycle.
module tb_inv_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [7:0]  cfg_mask = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [15:0] beat_cnt;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] exp_cnt = 16'd0;
  logic [1:0]  m_mode = 2'd0;
  logic [7:0]  m_mask = 8'hFF;
  int          m_accepted = 0;
  logic        live = 1'b0;

  inv_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_mode  (cfg_mode),
    .cfg_mask  (cfg_mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what an accepted beat should become under the current model configuration
  function automatic logic [7:0] model(input logic [7:0] d);
    case (m_mode)
      2'd0:    return d;
      2'd1:    return ~d;
      2'd2:    return d ^ m_mask;
      default: return (m_accepted % 2 == 0) ? ~d : d;
    endcase
  endfunction

  // One edge after reset release the block may take beats
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  // Monitor: check outputs mid-cycle, then predict what the coming edge does
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_out_data", {56'd0, out_data}, 64'd0);
      chk("rst_beat_cnt", {48'd0, beat_cnt}, 64'd0);
      exp_q.delete();
      exp_cnt    = 16'd0;
      m_mode     = 2'd0;
      m_mask     = 8'hFF;
      m_accepted = 0;
    end else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, live && (exp_q.size() < 2)});
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
      chk("beat_cnt", {48'd0, beat_cnt}, {48'd0, exp_cnt});
      if (out_valid && exp_q.size() > 0)
        chk("out_data", {56'd0, out_data}, {56'd0, exp_q[0]});
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        exp_cnt = exp_cnt + 16'd1;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data));
        m_accepted++;
      end
      if (cfg_we) begin
        m_mode = cfg_mode;
        m_mask = cfg_mask;
      end
    end
  end

  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy,
                       input logic we, input logic [1:0] m, input logic [7:0] mk);
    @(posedge clk);
    #2;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    cfg_we    = we;
    cfg_mode  = m;
    cfg_mask  = mk;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    rst_n    = 1'b0;
    repeat (n) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset(3);
    idle(2);

    // Inversion of a short stream
    drive(1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 8'h00);
    drive(1'b1, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00);
    drive(1'b1, 8'hA5, 1'b1, 1'b0, 2'd0, 8'h00);
    drive(1'b1, 8'hFF, 1'b1, 1'b0, 2'd0, 8'h00);
    idle(3);
    @(negedge clk);
    chk("cnt_after_3", {48'd0, beat_cnt}, 64'd3);

    // Masked inversion, mask changes on the same edge as an accept
    drive(1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 8'h0F);
    drive(1'b1, 8'h3C, 1'b1, 1'b0, 2'd2, 8'h0F);
    drive(1'b1, 8'h3C, 1'b1, 1'b1, 2'd2, 8'hF0);
    drive(1'b1, 8'h3C, 1'b1, 1'b0, 2'd2, 8'h00);
    idle(3);

    // Stall: three pushes with the sink blocked, then release
    drive(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 8'h00);
    drive(1'b1, 8'h11, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1'b1, 8'h22, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1'b1, 8'h33, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("held_data", {56'd0, out_data}, 64'h11);
    idle(4);

    // Reset with two beats queued
    drive(1'b1, 8'h44, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1'b1, 8'h55, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_beat_cnt", {48'd0, beat_cnt}, 64'd0);
    out_ready = 1'b1;
    do_reset(2);
    idle(4);

    // Alternating inversion from even parity
    drive(1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 8'h00);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h55, 1'b1, 1'b0, 2'd0, 8'h00);
    idle(3);

    // Randomized traffic with occasional reconfiguration
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, 2'($urandom), 8'($urandom));
    end
    idle(4);

    // Counter wrap
    do_reset(2);
    idle(2);
    for (int i = 0; i < 65534; i++) drive(1'b1, 8'($urandom), 1'b1, 1'b0, 2'd0, 8'h00);
    idle(3);
    @(negedge clk);
    chk("cnt_fffe", {48'd0, beat_cnt}, 64'hFFFE);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'($urandom), 1'b1, 1'b0, 2'd0, 8'h00);
    idle(3);
    @(negedge clk);
    chk("cnt_wrap_1", {48'd0, beat_cnt}, 64'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
